hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
Parametrised ID-stage hazard unit; next generation of the two-stage load-use/mfc0 stall logic. Handles N forwarding stages with youngest-match priority and M source operands. Adds a per-register pending-write scoreboard for long-latency writers that leave the pipeline (cache-miss loads, divider, CP0), plus a consecutive-stall watchdog. Drives the IF/ID stall.

Parameters:
NUM_SRC, 2, source operands checked per ID instruction
NUM_FWD, 2, forwarding stages checked; index 0 = youngest (EX), 1 = MEM, ...
REG_AW, 5, register address width; register 0 never hazards
PEND_W, 2, width of per-register outstanding-write counter
WB_BYPASS, 1, 1 = a completion in the same cycle resolves the hazard
TIMEOUT, 1024, consecutive stall cycles before hang_err

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
en  in  1  enables the stall output only; scoreboard always updates
src_used  in  NUM_SRC  operand i is read by the ID instruction
src_addr  in  NUM_SRC*REG_AW  operand addresses, operand i at bits [i*REG_AW +: REG_AW]
fwd_wr_en  in  NUM_FWD  stage s writes a GPR
fwd_wr_addr  in  NUM_FWD*REG_AW  stage s destination
fwd_ready  in  NUM_FWD  stage s result is available for forwarding this cycle
issue_valid  in  1  long-latency write leaves the pipeline this cycle
issue_dst  in  REG_AW  its destination
issue_ready  out  1  scoreboard can accept issue_dst
wb_valid  in  1  long-latency result written back
wb_dst  in  REG_AW  its destination
IF_ID_reg_stall  out  1  hold IF and ID; insert bubble
pending_any  out  1  any counter nonzero
stall_count  out  16  consecutive stall cycles, saturating
hang_err  out  1  sticky watchdog flag
sb_err  out  1  sticky: completion for a register with counter 0

Behaviour:
- Reset: all counters 0; stall_count 0; hang_err 0; sb_err 0. Combinational outputs after reset: IF_ID_reg_stall 0, pending_any 0, issue_ready 1.
- Forwarding hazard for operand i, only when src_used[i] and src_addr[i] != 0:
  - Find the lowest s with fwd_wr_en[s] and fwd_wr_addr[s] == src_addr[i].
  - Hazard if that stage has fwd_ready[s] = 0.
  - Older matching stages are ignored, whether ready or not.
- Scoreboard hazard for operand i, only when no forwarding stage matches: cnt[src_addr[i]] != 0.
  - Exception: with WB_BYPASS = 1, no hazard when cnt == 1 and wb_valid and wb_dst == src_addr[i] in the same cycle.
- IF_ID_reg_stall = en AND (OR of all operand hazards). Purely combinational, zero latency.
- Counters update at the posedge; issue_fire = issue_valid & issue_ready.
  - issue_fire only: cnt[issue_dst] + 1.
  - wb_valid only: cnt[wb_dst] - 1.
  - Both to the same register: unchanged.
  - Both to different registers: both update.
  - Address 0: never counted; issue to r0 is always ready; wb to r0 is ignored.
- issue_ready = 0 only when cnt[issue_dst] is all-ones and there is no same-cycle wb to issue_dst.
  - Upstream must hold the instruction while issue_ready = 0.
  - issue_valid while issue_ready = 0 has no effect.
- wb_valid with cnt[wb_dst] == 0: counter stays 0 (no underflow); sb_err set.
- stall_count: +1 (saturating at 0xFFFF) each cycle IF_ID_reg_stall = 1; cleared to 0 on any cycle it is 0.
- hang_err: set the cycle stall_count reaches TIMEOUT; cleared only by reset.
- Pipeline flush has no input. Issued long ops always complete, so counters are never flushed.
- Reset mid-operation clears all state. The owner of outstanding ops must also be reset.

Test Plan:
- Load-use: fwd_wr_en[0] = 1, addr 5, ready 0; src_addr[0] = 5, used → stall = 1. Same with src_addr = 0 or used = 0 → stall = 0. en = 0 → stall = 0.
- Youngest priority: stage0 writes r7 ready = 1, stage1 writes r7 ready = 0, src r7 → stall = 0. Swap the ready values → stall = 1.
- Scoreboard: issue r9 at cycle 0. Src r9 stalls from cycle 1. wb r9 at cycle 4 → stall = 0 in cycle 4 (WB_BYPASS = 1) and cnt = 0 after. pending_any follows.
- Saturation: three issues to r3 (PEND_W = 2) → issue_ready = 0 for r3. Issue plus wb to r3 in the same cycle → ready = 1, cnt stays 3. Issue to r4 → ready = 1.
- Errors: wb r12 with cnt 0 → sb_err = 1 sticky, cnt stays 0. Hold a hazard for TIMEOUT cycles → hang_err = 1, stall_count = 1024. Reset → all 0.
- Simultaneous issue r2 and wb r6 (cnt[r6] = 1) → cnt[r2] = 1, cnt[r6] = 0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard unit.
// Detects read-after-write hazards for NUM_SRC operands against NUM_FWD
// forwarding stages (youngest match wins) and against a per-register
// pending-write scoreboard of long-latency writers that leave the pipeline.
// It drives the IF/ID stall and runs a consecutive-stall watchdog.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   en                 gates the stall output only
//   src_used/src_addr  operands read by the ID instruction
//   fwd_wr_en/fwd_wr_addr/fwd_ready  forwarding stages, index 0 = youngest
//   issue_valid/issue_dst/issue_ready  long-latency write leaving the pipe
//   wb_valid/wb_dst    long-latency write-back
//   IF_ID_reg_stall    hold IF/ID, insert bubble (combinational)
//   pending_any        any outstanding long-latency write (combinational)
//   stall_count        consecutive stall cycles, saturating
//   hang_err           sticky watchdog flag
//   sb_err             sticky write-back with no outstanding write
module hazard_scoreboard #(
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned NUM_FWD   = 2,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned PEND_W    = 2,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_FWD-1:0]        fwd_wr_en,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wr_addr,
  input  logic [NUM_FWD-1:0]        fwd_ready,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_dst,
  output logic                      issue_ready,
  input  logic                      wb_valid,
  input  logic [REG_AW-1:0]         wb_dst,
  output logic                      IF_ID_reg_stall,
  output logic                      pending_any,
  output logic [15:0]               stall_count,
  output logic                      hang_err,
  output logic                      sb_err
);

  localparam int unsigned NUM_REGS = 1 << REG_AW;
  localparam int unsigned SC_W     = 16;

  // Outstanding long-latency writes per register; entry 0 is never written.
  logic [NUM_REGS-1:0][PEND_W-1:0] cnt;

  logic [NUM_SRC-1:0] src_hz;
  logic               issue_fire;
  logic               wb_eff;
  logic [SC_W-1:0]    stall_next;

  // Hazard for one operand address: youngest matching forwarding stage
  // decides; only with no match does the scoreboard count matter.
  function automatic logic operand_hazard(
    input logic [REG_AW-1:0]         a,
    input logic [PEND_W-1:0]         c,
    input logic [NUM_FWD-1:0]        wen,
    input logic [NUM_FWD*REG_AW-1:0] waddr,
    input logic [NUM_FWD-1:0]        rdy,
    input logic                      wbv,
    input logic [REG_AW-1:0]         wbd
  );
    logic hit;
    logic hz;
    hit = 1'b0;
    hz  = 1'b0;
    for (int s = 0; s < int'(NUM_FWD); s++) begin
      if (!hit && wen[s] && (waddr[s*REG_AW +: REG_AW] == a)) begin
        hit = 1'b1;
        hz  = !rdy[s];
      end
    end
    if (!hit && (c != '0)) begin
      hz = 1'b1;
      // Last outstanding write completing this cycle resolves the hazard.
      if ((WB_BYPASS != 0) && (c == PEND_W'(1)) && wbv && (wbd == a)) begin
        hz = 1'b0;
      end
    end
    return hz;
  endfunction

  // Per-operand hazards; r0 and unused operands never hazard.
  always_comb begin
    src_hz = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_hz[i] = src_used[i] && (src_addr[i*REG_AW +: REG_AW] != '0) &&
                  operand_hazard(src_addr[i*REG_AW +: REG_AW],
                                 cnt[src_addr[i*REG_AW +: REG_AW]],
                                 fwd_wr_en, fwd_wr_addr, fwd_ready,
                                 wb_valid, wb_dst);
    end
  end

  assign IF_ID_reg_stall = en && (|src_hz);
  assign pending_any     = |cnt;

  // A full counter still accepts when its own write-back frees a slot.
  assign issue_ready = (issue_dst == '0) || (cnt[issue_dst] != '1) ||
                       (wb_valid && (wb_dst == issue_dst));

  assign issue_fire = issue_valid && issue_ready && (issue_dst != '0);
  assign wb_eff     = wb_valid && (wb_dst != '0);

  assign stall_next = (stall_count == '1) ? stall_count : stall_count + SC_W'(1);

  // Scoreboard counters: same-register issue and write-back cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int r = 1; r < int'(NUM_REGS); r++) begin
        if (issue_fire && (issue_dst == REG_AW'(r)) &&
            !(wb_eff && (wb_dst == REG_AW'(r)))) begin
          cnt[r] <= cnt[r] + PEND_W'(1);
        end else if (wb_eff && (wb_dst == REG_AW'(r)) &&
                     !(issue_fire && (issue_dst == REG_AW'(r))) &&
                     (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - PEND_W'(1);
        end
      end
    end
  end

  // Sticky error on a write-back with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_err <= 1'b0;
    end else if (wb_eff && (cnt[wb_dst] == '0)) begin
      sb_err <= 1'b1;
    end
  end

  // Consecutive-stall counter and sticky watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      hang_err    <= 1'b0;
    end else if (IF_ID_reg_stall) begin
      stall_count <= stall_next;
      if (32'(stall_next) >= TIMEOUT) begin
        hang_err <= 1'b1;
      end
    end else begin
      stall_count <= '0;
    end
  end

endmodule
